song_sequencer_ctrl: RTL and testbench
======================================

# song_sequencer_ctrl

Transport controller that sequences the board's song note tables and selects among them. It generates the millisecond and step timebase, drives a shared step index into all song tables, and muxes the selected song's 16-bit note value to the tone generator. It also inserts an articulation gap at the end of each step and handles play/pause/stop/next/prev and looping. It replaces the per-song clock dividers and step counters.

## Interface
Parameters:
- SEL_W, 2: song-select width; NUM_SONGS = 2**SEL_W.
- PRESCALE, 50000: clk50 cycles per ms tick.
- GAP_TICKS, 20: ms ticks of silence at the end of each step.

Ports:
- clk50  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low.
- play  in  1  1-cycle pulse: start from IDLE or resume from PAUSED.
- pause  in  1  1-cycle pulse: freeze playback.
- stop  in  1  1-cycle pulse: return to IDLE.
- next  in  1  1-cycle pulse: select the next song.
- prev  in  1  1-cycle pulse: select the previous song.
- loop  in  1  1 = repeat the current song; 0 = auto-advance to the next song.
- step_len  in  8  step duration in ms ticks; 0 is treated as 1.
- song_len  in  NUM_SONGS*10  packed last-step index per song, song k at [10k+9:10k]; 0 is treated as 1.
- songs_in  in  NUM_SONGS*16  packed note values per song, song k at [16k+15:16k]; each is a combinational function of step_idx.
- step_idx  out  10  current step (1..len); 0 in IDLE.
- song_sel  out  SEL_W  selected song.
- tone  out  16  gated note value to the tone generator; 0 means silence.
- gate  out  1  note-on qualifier.
- beat  out  1  1-cycle pulse when a step starts.
- song_done  out  1  1-cycle pulse when the last step of a song completes.
- playing  out  1  high in PLAYING.
- paused  out  1  high in PAUSED.

## Operation
- States: IDLE, PLAYING, PAUSED. All outputs and counters are registered.
- Reset values: state IDLE; step_idx 0; song_sel 0; tone 0; gate 0; beat 0; song_done 0; playing 0; paused 0; prescale and step counters 0.
- Counters:
  - pcnt runs 0..PRESCALE-1 while PLAYING; ms_tick fires when pcnt = PRESCALE-1.
  - scnt counts ms_ticks within a step.
  - L = max(step_len, 1), sampled live.
  - N = max(song_len[song_sel], 1).
- IDLE:
  - step_idx = 0, tone = 0, gate = 0.
  - play → PLAYING: step_idx = 1, pcnt = scnt = 0, beat pulse.
- PLAYING, on an ms_tick with scnt ≥ L-1 (step end):
  - scnt = 0 and beat pulse.
  - If step_idx < N: step_idx + 1.
  - If step_idx ≥ N: song_done pulse and step_idx = 1. If loop = 0, song_sel = (song_sel + 1) mod NUM_SONGS; if loop = 1, song_sel is unchanged.
- PLAYING, any other ms_tick: scnt + 1.
- Gate:
  - gate = 1 when PLAYING and scnt < L - GAP_TICKS.
  - If GAP_TICKS ≥ L, gate = 1 for the whole step.
  - tone = gate ? songs_in[song_sel] : 0. A song-table rest (0) passes through as 0.
- pause in PLAYING → PAUSED: pcnt and scnt freeze, step_idx holds, gate = 0, tone = 0. pause in any other state is ignored.
- play in PAUSED → PLAYING, resuming from the frozen counters. No beat pulse.
- play in PLAYING is ignored.
- stop in any state → IDLE; clears step_idx and all counters; song_sel holds.
- next/prev: song_sel ±1 mod NUM_SONGS (wraps in both directions). State is unchanged. In PLAYING/PAUSED: step_idx = 1 and counters clear; beat pulses only in PLAYING. In IDLE: step_idx stays 0. No song_done.
- Simultaneous events, priority: stop > next > prev > pause > play > step end. Lower-priority events in the same cycle are dropped.
- Reducing step_len mid-step so that scnt ≥ L-1 makes the step end at the next ms_tick.

## Timing
- Control pulse at cycle t → state, step_idx, song_sel and beat update at t+1.
- tone and gate reflect the new step_idx/song_sel at t+2, because songs_in settles combinationally from step_idx and is then registered.
- Step period = L × PRESCALE cycles exactly; no drift across step ends or song wraps.
- Pause/resume preserves the remaining step time to within 1 clk50 cycle.
- Asynchronous reset mid-step forces all reset values immediately. Release resumes in IDLE.

## Test plan
- PRESCALE=4, GAP_TICKS=1, step_len=3, song_len[0]=3. After play: beat every 12 cycles; step_idx goes 1,2,3,1 (loop=1); song_done at the 3→1 transition; gate low during the last 4 cycles of each step.
- loop=0, NUM_SONGS=4, song_sel=3, last step reached → song_sel=0, step_idx=1, song_done=1 for one cycle.
- pause 5 cycles into a step, hold 100 cycles, then play → tone is 0 while paused; the step ends 7 cycles after resume; step_idx is unchanged across the pause.
- stop, next and play in the same cycle while PLAYING → IDLE, step_idx=0, song_sel unchanged, tone=0.
- prev with song_sel=0 in PAUSED → song_sel=3, step_idx=1, still PAUSED, no beat.
- step_len=0, GAP_TICKS=20 → a step is every PRESCALE cycles and gate stays high continuously; assert reset mid-step → all outputs return to 0 immediately.

Source files
------------

// File: rtl/song_sequencer_ctrl_if.sv
// song_sequencer_ctrl_if: transport controls, song tables and playback status
interface song_sequencer_ctrl_if #(parameter int SEL_W = 2);
  localparam int NUM_SONGS = 2**SEL_W;
  logic play, pause, stop, next, prev, loop;
  logic [7:0] step_len;
  logic [NUM_SONGS*10-1:0] song_len;
  logic [NUM_SONGS*16-1:0] songs_in;
  logic [9:0] step_idx;
  logic [SEL_W-1:0] song_sel;
  logic [15:0] tone;
  logic gate, beat, song_done, playing, paused;
  modport master (
    output play, pause, stop, next, prev, loop, step_len, song_len, songs_in,
    input step_idx, song_sel, tone, gate, beat, song_done, playing, paused
  );
  modport slave (
    input play, pause, stop, next, prev, loop, step_len, song_len, songs_in,
    output step_idx, song_sel, tone, gate, beat, song_done, playing, paused
  );
endinterface

// File: rtl/song_sequencer_ctrl.sv
// song_sequencer_ctrl: ms/step timebase, shared step index and song mux with articulation gap
module song_sequencer_ctrl #(
  parameter int SEL_W = 2,
  parameter int PRESCALE = 50000,
  parameter int GAP_TICKS = 20
) (
  input logic clk50,
  input logic reset,
  song_sequencer_ctrl_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, PLAYING, PAUSED} state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [7:0] scnt, scnt_n, l;
  logic [9:0] idx, idx_n, n, len_raw;
  logic [SEL_W-1:0] sel, sel_n;
  logic [15:0] note, tone;
  logic beat, beat_n, done, done_n, gate, gate_c, playing, paused, ms_tick, step_end, last;
  assign l = bus.step_len == 8'd0 ? 8'd1 : bus.step_len;
  assign len_raw = bus.song_len[10*sel +: 10];
  assign n = len_raw == 10'd0 ? 10'd1 : len_raw;
  assign note = bus.songs_in[16*sel +: 16];
  assign ms_tick = state == PLAYING && pcnt == PW'(PRESCALE - 1);
  assign step_end = ms_tick && scnt >= l - 8'd1;
  assign last = idx >= n;
  // a gap at least as long as the step would silence it entirely, so keep the note on instead
  assign gate_c = state == PLAYING && (GAP_TICKS >= int'(l) || int'(scnt) < int'(l) - GAP_TICKS);
  always_comb begin
    state_n = state;
    pcnt_n = pcnt;
    scnt_n = scnt;
    idx_n = idx;
    sel_n = sel;
    beat_n = 1'b0;
    done_n = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      idx_n = '0;
      pcnt_n = '0;
      scnt_n = '0;
    end else if (bus.next || bus.prev) begin
      sel_n = bus.next ? sel + 1'b1 : sel - 1'b1;
      if (state != IDLE) begin
        idx_n = 10'd1;
        pcnt_n = '0;
        scnt_n = '0;
        beat_n = state == PLAYING;
      end
    end else if (bus.pause && state == PLAYING) begin
      state_n = PAUSED;
    end else if (bus.play && state != PLAYING) begin
      state_n = PLAYING;
      if (state == IDLE) begin
        idx_n = 10'd1;
        pcnt_n = '0;
        scnt_n = '0;
        beat_n = 1'b1;
      end
    end else if (state == PLAYING) begin
      pcnt_n = ms_tick ? '0 : pcnt + 1'b1;
      if (step_end) begin
        scnt_n = '0;
        beat_n = 1'b1;
        done_n = last;
        idx_n = last ? 10'd1 : idx + 10'd1;
        sel_n = last && !bus.loop ? sel + 1'b1 : sel;
      end else if (ms_tick) begin
        scnt_n = scnt + 8'd1;
      end
    end
  end
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pcnt <= '0;
      scnt <= '0;
      idx <= '0;
      sel <= '0;
      beat <= 1'b0;
      done <= 1'b0;
      gate <= 1'b0;
      tone <= '0;
      playing <= 1'b0;
      paused <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      scnt <= scnt_n;
      idx <= idx_n;
      sel <= sel_n;
      beat <= beat_n;
      done <= done_n;
      gate <= gate_c;
      tone <= gate_c ? note : '0;
      playing <= state_n == PLAYING;
      paused <= state_n == PAUSED;
    end
  end
  assign bus.step_idx = idx;
  assign bus.song_sel = sel;
  assign bus.tone = tone;
  assign bus.gate = gate;
  assign bus.beat = beat;
  assign bus.song_done = done;
  assign bus.playing = playing;
  assign bus.paused = paused;
endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// tb_song_sequencer_ctrl: directed transport scenarios with hand-derived cycle timing
module tb_song_sequencer_ctrl;
  logic clk50 = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  song_sequencer_ctrl_if #(.SEL_W(2)) bus();
  song_sequencer_ctrl #(.SEL_W(2), .PRESCALE(4), .GAP_TICKS(1)) dut (
    .clk50(clk50),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk50 = ~clk50;
  // song k plays note {k+1, step}, so every table entry is non-zero and identifies its song
  assign bus.songs_in = {6'd4, bus.step_idx, 6'd3, bus.step_idx, 6'd2, bus.step_idx, 6'd1, bus.step_idx};
  function automatic logic [15:0] note_of(input int k, input logic [9:0] i);
    return {6'(k + 1), i};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask
  task automatic test_reset;
    cyc(2);
    checks++;
    if ({bus.step_idx, bus.song_sel, bus.tone, bus.gate, bus.beat, bus.song_done, bus.playing, bus.paused} !== '0)
      begin errors++; $display("FAIL reset: idx=%0d sel=%0d tone=%h gate=%b beat=%b done=%b pl=%b pa=%b, want all 0", bus.step_idx, bus.song_sel, bus.tone, bus.gate, bus.beat, bus.song_done, bus.playing, bus.paused); end
    reset = 1'b1;
    cyc(1);
    checks++;
    if (bus.playing !== 1'b0 || bus.step_idx !== 10'd0)
      begin errors++; $display("FAIL reset_release: playing=%b idx=%0d, want 0 0", bus.playing, bus.step_idx); end
  endtask
  task automatic test_sequence;
    logic [9:0] cur, nxt;
    logic gexp;
    bus.loop = 1'b1;
    bus.step_len = 8'd3;
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    checks++;
    if (bus.beat !== 1'b1 || bus.step_idx !== 10'd1 || bus.playing !== 1'b1)
      begin errors++; $display("FAIL play_start: beat=%b idx=%0d playing=%b, want 1 1 1", bus.beat, bus.step_idx, bus.playing); end
    cur = 10'd1;
    for (int s = 0; s < 4; s++)
      for (int k = 1; k <= 12; k++) begin
        cyc(1);
        gexp = k <= 8;
        checks++;
        if (bus.gate !== gexp)
          begin errors++; $display("FAIL seq_gate s%0d k%0d: got %b want %b", s, k, bus.gate, gexp); end
        checks++;
        if (bus.tone !== (gexp ? note_of(0, cur) : 16'h0))
          begin errors++; $display("FAIL seq_tone s%0d k%0d: got %h want %h", s, k, bus.tone, gexp ? note_of(0, cur) : 16'h0); end
        checks++;
        if (bus.beat !== (k == 12))
          begin errors++; $display("FAIL seq_beat s%0d k%0d: got %b want %b", s, k, bus.beat, k == 12); end
        if (k == 12) begin
          nxt = cur == 10'd3 ? 10'd1 : cur + 10'd1;
          checks++;
          if (bus.step_idx !== nxt || bus.song_done !== (cur == 10'd3))
            begin errors++; $display("FAIL seq_step s%0d: idx=%0d done=%b want %0d %b", s, bus.step_idx, bus.song_done, nxt, cur == 10'd3); end
          cur = nxt;
        end else begin
          checks++;
          if (bus.step_idx !== cur || bus.song_done !== 1'b0)
            begin errors++; $display("FAIL seq_hold s%0d k%0d: idx=%0d done=%b want %0d 0", s, k, bus.step_idx, bus.song_done, cur); end
        end
      end
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
  endtask
  task automatic test_autoadvance;
    bus.loop = 1'b0;
    bus.prev = 1'b1; cyc(1); bus.prev = 1'b0;
    checks++;
    if (bus.song_sel !== 2'd3 || bus.step_idx !== 10'd0 || bus.playing !== 1'b0)
      begin errors++; $display("FAIL prev_idle: sel=%0d idx=%0d playing=%b, want 3 0 0", bus.song_sel, bus.step_idx, bus.playing); end
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    cyc(12);
    checks++;
    if (bus.step_idx !== 10'd2 || bus.song_sel !== 2'd3 || bus.song_done !== 1'b0 || bus.beat !== 1'b1)
      begin errors++; $display("FAIL adv_step2: idx=%0d sel=%0d done=%b beat=%b, want 2 3 0 1", bus.step_idx, bus.song_sel, bus.song_done, bus.beat); end
    cyc(12);
    checks++;
    if (bus.step_idx !== 10'd1 || bus.song_sel !== 2'd0 || bus.song_done !== 1'b1 || bus.beat !== 1'b1)
      begin errors++; $display("FAIL adv_wrap: idx=%0d sel=%0d done=%b beat=%b, want 1 0 1 1", bus.step_idx, bus.song_sel, bus.song_done, bus.beat); end
    cyc(1);
    checks++;
    if (bus.song_done !== 1'b0 || bus.tone !== note_of(0, 10'd1))
      begin errors++; $display("FAIL adv_after: done=%b tone=%h, want 0 %h", bus.song_done, bus.tone, note_of(0, 10'd1)); end
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    bus.loop = 1'b1;
  endtask
  task automatic test_pause;
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    cyc(5);
    bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
    checks++;
    if (bus.paused !== 1'b1 || bus.playing !== 1'b0)
      begin errors++; $display("FAIL pause_state: paused=%b playing=%b, want 1 0", bus.paused, bus.playing); end
    cyc(1);
    checks++;
    if (bus.tone !== 16'h0 || bus.gate !== 1'b0)
      begin errors++; $display("FAIL pause_silent: tone=%h gate=%b, want 0 0", bus.tone, bus.gate); end
    cyc(98);
    checks++;
    if (bus.tone !== 16'h0 || bus.step_idx !== 10'd1 || bus.beat !== 1'b0)
      begin errors++; $display("FAIL pause_hold: tone=%h idx=%0d beat=%b, want 0 1 0", bus.tone, bus.step_idx, bus.beat); end
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    checks++;
    if (bus.playing !== 1'b1 || bus.beat !== 1'b0 || bus.step_idx !== 10'd1)
      begin errors++; $display("FAIL resume: playing=%b beat=%b idx=%0d, want 1 0 1", bus.playing, bus.beat, bus.step_idx); end
    for (int j = 1; j <= 7; j++) begin
      cyc(1);
      checks++;
      if (bus.beat !== (j == 7) || bus.step_idx !== (j == 7 ? 10'd2 : 10'd1))
        begin errors++; $display("FAIL resume_end j%0d: beat=%b idx=%0d, want %b %0d", j, bus.beat, bus.step_idx, j == 7, j == 7 ? 2 : 1); end
    end
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
  endtask
  task automatic test_simultaneous;
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    cyc(3);
    bus.stop = 1'b1; bus.next = 1'b1; bus.play = 1'b1;
    cyc(1);
    bus.stop = 1'b0; bus.next = 1'b0; bus.play = 1'b0;
    checks++;
    if (bus.playing !== 1'b0 || bus.paused !== 1'b0 || bus.step_idx !== 10'd0 || bus.song_sel !== 2'd0)
      begin errors++; $display("FAIL stop_prio: pl=%b pa=%b idx=%0d sel=%0d, want 0 0 0 0", bus.playing, bus.paused, bus.step_idx, bus.song_sel); end
    cyc(1);
    checks++;
    if (bus.tone !== 16'h0 || bus.gate !== 1'b0)
      begin errors++; $display("FAIL stop_silent: tone=%h gate=%b, want 0 0", bus.tone, bus.gate); end
  endtask
  task automatic test_prev_paused;
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    cyc(12);
    checks++;
    if (bus.step_idx !== 10'd2)
      begin errors++; $display("FAIL pp_step2: idx=%0d want 2", bus.step_idx); end
    bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
    bus.prev = 1'b1; cyc(1); bus.prev = 1'b0;
    checks++;
    if (bus.song_sel !== 2'd3 || bus.step_idx !== 10'd1 || bus.paused !== 1'b1 || bus.beat !== 1'b0)
      begin errors++; $display("FAIL prev_paused: sel=%0d idx=%0d paused=%b beat=%b, want 3 1 1 0", bus.song_sel, bus.step_idx, bus.paused, bus.beat); end
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    bus.next = 1'b1; cyc(1); bus.next = 1'b0;
    checks++;
    if (bus.song_sel !== 2'd0 || bus.step_idx !== 10'd0)
      begin errors++; $display("FAIL next_wrap: sel=%0d idx=%0d, want 0 0", bus.song_sel, bus.step_idx); end
  endtask
  task automatic test_steplen0_reset;
    bus.step_len = 8'd0;
    bus.next = 1'b1; cyc(1); bus.next = 1'b0;
    bus.play = 1'b1; cyc(1); bus.play = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int k = 1; k <= 4; k++) begin
        cyc(1);
        checks++;
        if (bus.gate !== 1'b1 || bus.tone !== note_of(1, 10'd1))
          begin errors++; $display("FAIL l0_gate s%0d k%0d: gate=%b tone=%h, want 1 %h", s, k, bus.gate, bus.tone, note_of(1, 10'd1)); end
        checks++;
        if (bus.beat !== (k == 4) || bus.song_done !== (k == 4) || bus.step_idx !== 10'd1)
          begin errors++; $display("FAIL l0_beat s%0d k%0d: beat=%b done=%b idx=%0d, want %b %b 1", s, k, bus.beat, bus.song_done, bus.step_idx, k == 4, k == 4); end
      end
    cyc(2);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.step_idx, bus.song_sel, bus.tone, bus.gate, bus.beat, bus.song_done, bus.playing, bus.paused} !== '0)
      begin errors++; $display("FAIL async_reset: idx=%0d sel=%0d tone=%h gate=%b pl=%b, want all 0", bus.step_idx, bus.song_sel, bus.tone, bus.gate, bus.playing); end
    cyc(1);
    reset = 1'b1;
    cyc(2);
    checks++;
    if (bus.playing !== 1'b0 || bus.step_idx !== 10'd0 || bus.gate !== 1'b0)
      begin errors++; $display("FAIL reset_idle: playing=%b idx=%0d gate=%b, want 0 0 0", bus.playing, bus.step_idx, bus.gate); end
  endtask
  initial begin
    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.next = 1'b0; bus.prev = 1'b0; bus.loop = 1'b1;
    bus.step_len = 8'd3;
    bus.song_len = {10'd2, 10'd1, 10'd1, 10'd3};
    test_reset;
    test_sequence;
    test_autoadvance;
    test_pause;
    test_simultaneous;
    test_prev_paused;
    test_steplen0_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
